// File: rtl/piso_lane_serializer.sv
// Parallel-in/serial-out lane serializer: takes one DATA_WIDTH word per valid/ready handshake
// and emits it as BEATS = DATA_WIDTH/LANE_WIDTH beats of LANE_WIDTH bits, LSB- or MSB-lane first.
// Latency: first beat one cycle after accept; Enable=0 stalls indefinitely; back-to-back words with no bubble.
module piso_lane_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DATA,
    input  logic                  Data_Valid,
    input  logic                  MSB_First,
    input  logic                  Enable,
    output logic                  Ready,
    output logic [LANE_WIDTH-1:0] ser_out,
    output logic                  ser_valid,
    output logic                  ser_done,
    output logic                  Busy
);

    localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    // Reject lane widths that do not tile the word exactly.
    generate
        if (LANE_WIDTH < 1 || (DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_params
            $error("piso_lane_serializer: LANE_WIDTH must be >= 1 and divide DATA_WIDTH");
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   sr_q, sr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    msb_q, msb_d;

    logic [DATA_WIDTH-1:0]   sr_shl;
    logic [DATA_WIDTH-1:0]   sr_shr;
    logic                    last_beat;

    // With a single beat per word nothing remains after a shift, so the
    // shifted views are simply zero (avoids a shift by the full width).
    generate
        if (BEATS == 1) begin : g_one_beat
            assign sr_shl = '0;
            assign sr_shr = '0;
        end else begin : g_multi_beat
            assign sr_shl = sr_q << LANE_WIDTH;
            assign sr_shr = sr_q >> LANE_WIDTH;
        end
    endgenerate

    assign last_beat = (cnt_q == LAST_BEAT);

    // State, shift register, beat counter and latched bit order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
        end
    end

    // Next-state and outputs; a load is taken whenever Ready and Data_Valid meet.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        msb_d     = msb_q;
        Ready     = 1'b0;
        ser_out   = '0;
        ser_valid = 1'b0;
        ser_done  = 1'b0;
        Busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                Ready = 1'b1;
                if (Data_Valid) begin
                    sr_d    = DATA;
                    msb_d   = MSB_First;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                ser_valid = 1'b1;
                Busy      = 1'b1;
                // Lane bit i always carries the higher-order data bit as i rises.
                ser_out   = msb_q ? sr_q[DATA_WIDTH-1 -: LANE_WIDTH]
                                  : sr_q[LANE_WIDTH-1:0];
                if (Enable) begin
                    if (last_beat) begin
                        // Last beat is consumed this edge: open the door for the next word.
                        Ready    = 1'b1;
                        ser_done = 1'b1;
                        if (Data_Valid) begin
                            sr_d  = DATA;
                            msb_d = MSB_First;
                            cnt_d = '0;
                        end else begin
                            sr_d    = '0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        sr_d  = msb_q ? sr_shl : sr_shr;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_lane_serializer.sv
// Directed bench for piso_lane_serializer: one 1-bit-lane and one 2-bit-lane instance.
// Expected beat sequences are hand-computed constants; each beat is sampled between clock edges.
// Stalls, back-to-back loads, mid-frame order toggles and mid-frame reset are exercised.
module tb_piso_lane_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] DATA;
    logic       MSB_First;
    logic       Enable;
    logic       dv1, dv2;

    logic       rdy1, sv1, sd1, busy1;
    logic [0:0] so1;
    logic       rdy2, sv2, sd2, busy2;
    logic [1:0] so2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    piso_lane_serializer #(.DATA_WIDTH(8), .LANE_WIDTH(1)) u_dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .DATA       (DATA),
        .Data_Valid (dv1),
        .MSB_First  (MSB_First),
        .Enable     (Enable),
        .Ready      (rdy1),
        .ser_out    (so1),
        .ser_valid  (sv1),
        .ser_done   (sd1),
        .Busy       (busy1)
    );

    piso_lane_serializer #(.DATA_WIDTH(8), .LANE_WIDTH(2)) u_dut2 (
        .CLK        (CLK),
        .RST        (RST),
        .DATA       (DATA),
        .Data_Valid (dv2),
        .MSB_First  (MSB_First),
        .Enable     (Enable),
        .Ready      (rdy2),
        .ser_out    (so2),
        .ser_valid  (sv2),
        .ser_done   (sd2),
        .Busy       (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One word through the 1-bit lane; e[i] is the expected beat i.
    // stall_at/stall_len hold Enable low for stall_len cycles while beat stall_at is shown,
    // offering a junk word during the stall.
    task automatic run1(input string tag, input logic [7:0] w, input logic msb,
                        input logic [7:0] e, input logic tog,
                        input int stall_at, input int stall_len);
        int   beat;
        int   cyc;
        int   st;
        logic en;
        check({tag, ".rdy_idle"}, rdy1, 1);
        DATA      = w;
        MSB_First = msb;
        dv1       = 1'b1;
        Enable    = 1'b1;
        @(negedge CLK);
        dv1  = 1'b0;
        DATA = 8'h00;
        beat = 0;
        cyc  = 0;
        st   = 0;
        while (beat < 8 && cyc < 40) begin
            en = !(beat == stall_at && st < stall_len);
            Enable = en;
            if (!en) begin
                dv1  = 1'b1;
                DATA = 8'hFF;
                st++;
            end else begin
                dv1 = 1'b0;
            end
            #1;
            check($sformatf("%s.vld%0d", tag, cyc), sv1, 1);
            check($sformatf("%s.out%0d", tag, cyc), so1, e[beat]);
            check($sformatf("%s.done%0d", tag, cyc), sd1, (en && beat == 7));
            check($sformatf("%s.rdy%0d", tag, cyc), rdy1, (en && beat == 7));
            if (tog) MSB_First = ~MSB_First;
            if (en) beat++;
            cyc++;
            @(negedge CLK);
        end
        dv1  = 1'b0;
        DATA = 8'h00;
        check({tag, ".cycles"}, cyc, 8 + stall_len);
        #1;
        check({tag, ".busy_end"}, busy1, 0);
        check({tag, ".vld_end"}, sv1, 0);
        check({tag, ".out_end"}, so1, 0);
        check({tag, ".rdy_end"}, rdy1, 1);
    endtask

    // One word through the 2-bit lane; e[2i+:2] is the expected beat i.
    task automatic run2(input string tag, input logic [7:0] w, input logic msb, input logic [7:0] e);
        int dones;
        DATA      = w;
        MSB_First = msb;
        dv2       = 1'b1;
        Enable    = 1'b1;
        @(negedge CLK);
        dv2   = 1'b0;
        DATA  = 8'h00;
        dones = 0;
        for (int b = 0; b < 4; b++) begin
            #1;
            check($sformatf("%s.vld%0d", tag, b), sv2, 1);
            check($sformatf("%s.out%0d", tag, b), so2, e[2*b +: 2]);
            if (sd2) dones++;
            @(negedge CLK);
        end
        #1;
        check({tag, ".dones"}, dones, 1);
        check({tag, ".idle"}, busy2, 0);
        check({tag, ".vld_end"}, sv2, 0);
    endtask

    // Two words back to back with Data_Valid held; beats 0-7 then 8-15.
    task automatic run_b2b();
        logic [15:0] e16;
        e16       = 16'h0FB4;
        DATA      = 8'hB4;
        MSB_First = 1'b0;
        dv1       = 1'b1;
        Enable    = 1'b1;
        @(negedge CLK);
        DATA = 8'h0F;
        for (int b = 0; b < 16; b++) begin
            dv1 = (b < 8);
            #1;
            check($sformatf("b2b.vld%0d", b), sv1, 1);
            check($sformatf("b2b.out%0d", b), so1, e16[b]);
            check($sformatf("b2b.done%0d", b), sd1, (b == 7 || b == 15));
            @(negedge CLK);
        end
        dv1  = 1'b0;
        DATA = 8'h00;
        #1;
        check("b2b.idle", busy1, 0);
        check("b2b.vld_end", sv1, 0);
    endtask

    // Reset asserted while beat 4 is on the wire.
    task automatic run_reset();
        DATA      = 8'hB4;
        MSB_First = 1'b0;
        dv1       = 1'b1;
        Enable    = 1'b1;
        @(negedge CLK);
        dv1  = 1'b0;
        DATA = 8'h00;
        repeat (4) @(negedge CLK);
        #1;
        check("rst.pre_busy", busy1, 1);
        check("rst.pre_out", so1, 1);
        RST = 1'b0;
        #1;
        check("rst.rdy", rdy1, 1);
        check("rst.vld", sv1, 0);
        check("rst.out", so1, 0);
        check("rst.done", sd1, 0);
        check("rst.busy", busy1, 0);
        @(negedge CLK);
        check("rst.hold_done", sd1, 0);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RST       = 1'b0;
        DATA      = 8'h00;
        MSB_First = 1'b0;
        Enable    = 1'b0;
        dv1       = 1'b0;
        dv2       = 1'b0;
        #1;
        check("reset.rdy1", rdy1, 1);
        check("reset.vld1", sv1, 0);
        check("reset.done1", sd1, 0);
        check("reset.busy1", busy1, 0);
        check("reset.out1", so1, 0);
        check("reset.rdy2", rdy2, 1);
        check("reset.out2", so2, 0);
        check("reset.vld2", sv2, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        run1("lsb", 8'hB4, 1'b0, 8'hB4, 1'b0, 8, 0);
        run1("msb", 8'hB4, 1'b1, 8'h2D, 1'b0, 8, 0);
        run1("msb_tog", 8'hB4, 1'b1, 8'h2D, 1'b1, 8, 0);
        run2("l2_lsb", 8'hB4, 1'b0, 8'hB4);
        run2("l2_msb", 8'hB4, 1'b1, 8'h1E);
        run_b2b();
        run1("stall", 8'hB4, 1'b0, 8'hB4, 1'b0, 3, 3);
        run_reset();
        run1("post_rst", 8'h0F, 1'b0, 8'h0F, 1'b0, 8, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_lane_serializer.md
Name: piso_lane_serializer

Overview:
Parametrised parallel-in/serial-out converter. It accepts a DATA_WIDTH word through a valid/ready handshake and emits it over LANE_WIDTH-bit beats, with run-time selectable bit order and stall support. It supports back-to-back words with zero idle cycles and sits between the frame/packet builders and the line-side drivers.

Parameters:
DATA_WIDTH, 8, width of the parallel input word.
LANE_WIDTH, 1, bits emitted per beat. DATA_WIDTH mod LANE_WIDTH must be 0 and LANE_WIDTH >= 1; otherwise elaboration fails.
(Derived) BEATS = DATA_WIDTH/LANE_WIDTH. Beat counter width = max(1, $clog2(BEATS)).

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
DATA  input  DATA_WIDTH  parallel word
Data_Valid  input  1  DATA is offered this cycle
MSB_First  input  1  bit order. 1 = most-significant lane first. Sampled only at load.
Enable  input  1  advance one beat this cycle. 0 = stall.
Ready  output  1  word will be accepted at this edge if Data_Valid=1
ser_out  output  LANE_WIDTH  current beat
ser_valid  output  1  ser_out carries a valid beat
ser_done  output  1  single-cycle pulse on the last beat of a word as it is consumed
Busy  output  1  a word is in flight (state SHIFT)

Behaviour:
- Reset (async, RST=0):
  - state=IDLE; shift register, beat counter and latched order all cleared.
  - Outputs: Ready=1, ser_valid=0, ser_done=0, Busy=0, ser_out=0.
- States: IDLE, SHIFT.
- IDLE:
  - Ready=1, ser_valid=0, ser_out=0.
  - Data_Valid=1 at edge: latch DATA and MSB_First, counter=0, go to SHIFT. Enable is ignored in IDLE.
- SHIFT:
  - ser_valid=1, Busy=1.
  - ser_out in LSB-first mode = lowest LANE_WIDTH bits of the word not yet sent. MSB-first mode = highest LANE_WIDTH bits not yet sent.
  - Within a lane, lane bit i maps to the higher-order data bit as i rises, in both modes.
- Advance: in SHIFT with Enable=1, at the edge, shift by LANE_WIDTH in the selected direction and increment the counter. Zeros fill the vacated bits.
- Stall: Enable=0 holds the register, counter and ser_out unchanged, indefinitely.
- Last beat (counter==BEATS-1):
  - ser_done = Enable (combinational), so ser_done is high for exactly one cycle per word.
  - Ready = Enable.
- Back-to-back: last beat with Enable=1 and Data_Valid=1 → load the new word at that edge, stay in SHIFT, counter=0. No bubble; a new word needs BEATS cycles.
- Last beat with Enable=1 and Data_Valid=0 → IDLE next cycle.
- Data_Valid while Ready=0: ignored. DATA is not captured and the frame in flight is unaffected. The source must hold Data_Valid until Ready.
- MSB_First changes mid-frame have no effect; the order is fixed per word at load.
- BEATS=1 (LANE_WIDTH=DATA_WIDTH):
  - Every SHIFT cycle is the last beat.
  - With Enable and Data_Valid held high, one word per cycle.
- Latency: word accepted at edge k; first beat valid in cycle k+1; ser_done in cycle k+BEATS if there is no stall.
- Reset asserted mid-frame: the word is discarded immediately, with no ser_done; outputs take their reset values asynchronously.
- Counter never wraps past BEATS-1; it reloads to 0 on load or on the transition to IDLE.

Test Plan:
1. DATA_WIDTH=8, LANE_WIDTH=1, MSB_First=0, DATA=0xB4, Enable=1 → ser_out 0,0,1,0,1,1,0,1 on cycles 1-8; ser_done only in cycle 8; Ready=0 cycles 1-7; IDLE in cycle 9.
2. Same word, MSB_First=1 → 1,0,1,1,0,1,0,0. Toggle MSB_First mid-frame → sequence unchanged.
3. LANE_WIDTH=2, DATA=0xB4 → LSB-first beats 0,1,3,2; MSB-first beats 2,3,1,0; 4 cycles each; one ser_done.
4. LANE_WIDTH=1, 0xB4 then 0x0F with Data_Valid held, Enable=1 → 16 consecutive valid beats, no gap; ser_done at beats 8 and 16; second word bits 1,1,1,1,0,0,0,0 (LSB-first).
5. Enable=0 for 3 cycles after beat 3 → ser_out holds bit 3 value; frame completes in 11 cycles; Data_Valid pulses with a new word during the stall are ignored.
6. RST=0 at beat 5 → Ready=1, ser_valid=0, ser_out=0 immediately, no ser_done; a new word loads cleanly after release.
